// File: rtl/square_sweep_ctrl_if.sv
// square_sweep_ctrl_if: configuration, control and generator-side signals of the sweep sequencer
interface square_sweep_ctrl_if #(parameter int DWELL_W = 12);
  logic cfg_we;
  logic [2:0] cfg_addr;
  logic [2:0] cfg_freq;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [2:0] seq_len;
  logic start;
  logic abort;
  logic loop;
  logic [2:0] freq_select;
  logic gen_reset;
  logic busy;
  logic done;
  logic [2:0] step_idx;
  modport master(
    output cfg_we, cfg_addr, cfg_freq, cfg_dwell, seq_len, start, abort, loop,
    input freq_select, gen_reset, busy, done, step_idx
  );
  modport slave(
    input cfg_we, cfg_addr, cfg_freq, cfg_dwell, seq_len, start, abort, loop,
    output freq_select, gen_reset, busy, done, step_idx
  );
endinterface

// File: rtl/square_sweep_ctrl.sv
// square_sweep_ctrl: plays up to 8 programmed (freq, dwell) steps into the square-wave generator.
// Define SWEEP_LOOP_EN to let a latched loop request wrap the last step back to step 0.
module square_sweep_ctrl #(
  parameter int TICK_DIV = 25000,
  parameter int DWELL_W  = 12
) (
  input logic clk,
  input logic reset,
  square_sweep_ctrl_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam int PW = $clog2(TICK_DIV);
  logic [0:0] state;
  logic [2:0] freq_tab [8];
  logic [DWELL_W-1:0] dwell_tab [8];
  logic [PW-1:0] pre;
  logic [DWELL_W-1:0] cnt;
  logic [2:0] len_q;
  logic [2:0] nxt;
  logic accept, tick, expire, last, wrap;
  // a zero dwell would otherwise never expire, so it plays as one tick
  function automatic logic [DWELL_W-1:0] dw1(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction
  assign accept = (state == IDLE) && bus.start && !bus.abort;
  assign tick   = pre == PW'(TICK_DIV - 1);
  assign expire = tick && (cnt == DWELL_W'(1));
  assign last   = bus.step_idx == len_q;
  assign nxt    = last ? 3'd0 : bus.step_idx + 3'd1;
`ifdef SWEEP_LOOP_EN
  logic loop_q;
  assign wrap = loop_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) loop_q <= 1'b0;
    else if (accept) loop_q <= bus.loop;
`else
  logic unused_loop;
  assign unused_loop = bus.loop;
  assign wrap = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      pre             <= '0;
      cnt             <= DWELL_W'(1);
      len_q           <= 3'd0;
      bus.freq_select <= 3'd0;
      bus.gen_reset   <= 1'b1;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.step_idx    <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        freq_tab[i]  <= 3'd0;
        dwell_tab[i] <= DWELL_W'(1);
      end
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE) begin
        if (bus.cfg_we && !accept) begin
          freq_tab[bus.cfg_addr]  <= bus.cfg_freq;
          dwell_tab[bus.cfg_addr] <= bus.cfg_dwell;
        end
        if (accept) begin
          state           <= RUN;
          len_q           <= bus.seq_len;
          bus.step_idx    <= 3'd0;
          bus.freq_select <= freq_tab[0];
          cnt             <= dw1(dwell_tab[0]);
          pre             <= '0;
          bus.busy        <= 1'b1;
          bus.gen_reset   <= 1'b0;
        end
      end else if (bus.abort || (expire && last && !wrap)) begin
        state           <= IDLE;
        bus.busy        <= 1'b0;
        bus.gen_reset   <= 1'b1;
        bus.freq_select <= 3'd0;
        bus.step_idx    <= 3'd0;
        bus.done        <= !bus.abort;
      end else if (expire) begin
        bus.step_idx    <= nxt;
        bus.freq_select <= freq_tab[nxt];
        cnt             <= dw1(dwell_tab[nxt]);
        pre             <= '0;
      end else begin
        pre <= tick ? '0 : pre + PW'(1);
        if (tick) cnt <= cnt - DWELL_W'(1);
      end
    end
  end
endmodule
